// File: rtl/mem_wb_stage_if.sv
//------------------------------------------------------------------------------
// mem_wb_stage_if : MEM-stage capture bus and WB-stage result bus.
// Revision 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

interface mem_wb_stage_if #(
    parameter int NB_DATA = 32,
    parameter int NB_REG  = 5,
    parameter int NB_CNT  = 16
);
    logic               i_MEM_valid;
    logic               i_MEM_reg_write;
    logic               i_MEM_mem_to_reg;
    logic               i_MEM_byte_en;
    logic               i_MEM_halfword_en;
    logic               i_MEM_word_en;
    logic               i_MEM_unsigned;
    logic               i_MEM_halt;
    logic [NB_DATA-1:0] i_MEM_mem_data;
    logic [NB_DATA-1:0] i_MEM_alu_result;
    logic [NB_REG-1:0]  i_MEM_selected_reg;

    logic               o_WB_valid;
    logic               o_WB_reg_write;
    logic [NB_REG-1:0]  o_WB_selected_reg;
    logic [NB_DATA-1:0] o_WB_write_data;
    logic               o_WB_misaligned;
    logic               o_WB_halt;
    logic [NB_CNT-1:0]  o_WB_retired;

    modport master (
        output i_MEM_valid, i_MEM_reg_write, i_MEM_mem_to_reg, i_MEM_byte_en,
               i_MEM_halfword_en, i_MEM_word_en, i_MEM_unsigned, i_MEM_halt,
               i_MEM_mem_data, i_MEM_alu_result, i_MEM_selected_reg,
        input  o_WB_valid, o_WB_reg_write, o_WB_selected_reg, o_WB_write_data,
               o_WB_misaligned, o_WB_halt, o_WB_retired
    );

    modport slave (
        input  i_MEM_valid, i_MEM_reg_write, i_MEM_mem_to_reg, i_MEM_byte_en,
               i_MEM_halfword_en, i_MEM_word_en, i_MEM_unsigned, i_MEM_halt,
               i_MEM_mem_data, i_MEM_alu_result, i_MEM_selected_reg,
        output o_WB_valid, o_WB_reg_write, o_WB_selected_reg, o_WB_write_data,
               o_WB_misaligned, o_WB_halt, o_WB_retired
    );
endinterface

`default_nettype wire

// File: rtl/mem_wb_stage.sv
//------------------------------------------------------------------------------
// mem_wb_stage : MEM/WB pipeline register, load extraction, write-back select,
//                sticky halt and saturating retired-instruction counter.
// Optional macro: MEM_WB_MISALIGN_TRAP_EN (misaligned load trap).
// Revision 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module mem_wb_stage #(
    parameter int NB_DATA = 32,
    parameter int NB_REG  = 5,
    parameter int NB_CNT  = 16
) (
    input  wire logic      i_clock,
    input  wire logic      i_reset,
    input  wire logic      i_enable,
    input  wire logic      i_flush,
    mem_wb_stage_if.slave  bus
);

    localparam logic [NB_CNT-1:0] CNT_MAX = {NB_CNT{1'b1}};

    logic               valid_q,      valid_d;
    logic               reg_write_q,  reg_write_d;
    logic [NB_REG-1:0]  sel_reg_q,    sel_reg_d;
    logic [NB_DATA-1:0] write_data_q, write_data_d;
    logic               misaligned_q, misaligned_d;
    logic               halt_q,       halt_d;
    logic [NB_CNT-1:0]  retired_q,    retired_d;

    logic [1:0]         offset;
    logic               is_word;
    logic               is_half;
    logic               sign_fill;
    logic [7:0]         byte_lane;
    logic [15:0]        half_lane;
    logic [NB_DATA-1:0] load_value;
    logic               valid_in;
    logic               misaligned;

    // Load extraction: word > halfword > byte, no enable behaves as a word.
    always_comb begin
        offset    = bus.i_MEM_alu_result[1:0];
        is_word   = bus.i_MEM_word_en | ~(bus.i_MEM_halfword_en | bus.i_MEM_byte_en);
        is_half   = ~bus.i_MEM_word_en & bus.i_MEM_halfword_en;
        byte_lane = bus.i_MEM_mem_data[31:24];
        case (offset)
            2'd0:    byte_lane = bus.i_MEM_mem_data[7:0];
            2'd1:    byte_lane = bus.i_MEM_mem_data[15:8];
            2'd2:    byte_lane = bus.i_MEM_mem_data[23:16];
            default: byte_lane = bus.i_MEM_mem_data[31:24];
        endcase
        half_lane = offset[1] ? bus.i_MEM_mem_data[31:16] : bus.i_MEM_mem_data[15:0];
        if (is_word) begin
            sign_fill  = 1'b0;
            load_value = bus.i_MEM_mem_data;
        end else if (is_half) begin
            sign_fill  = half_lane[15] & ~bus.i_MEM_unsigned;
            load_value = {{(NB_DATA-16){sign_fill}}, half_lane};
        end else begin
            sign_fill  = byte_lane[7] & ~bus.i_MEM_unsigned;
            load_value = {{(NB_DATA-8){sign_fill}}, byte_lane};
        end
    end

    // Once halted, later instructions are squashed into non-valid slots.
    always_comb begin
        valid_in = bus.i_MEM_valid & ~halt_q;
`ifdef MEM_WB_MISALIGN_TRAP_EN
        misaligned = valid_in & bus.i_MEM_mem_to_reg &
                     ((is_half & offset[0]) | (is_word & (offset != 2'd0)));
`else
        misaligned = 1'b0;
`endif
    end

    always_comb begin
        valid_d      = valid_q;
        reg_write_d  = reg_write_q;
        sel_reg_d    = sel_reg_q;
        write_data_d = write_data_q;
        misaligned_d = misaligned_q;
        halt_d       = halt_q;
        retired_d    = retired_q;
        if (i_flush) begin
            valid_d      = 1'b0;
            reg_write_d  = 1'b0;
            sel_reg_d    = '0;
            write_data_d = '0;
            misaligned_d = 1'b0;
        end else if (i_enable) begin
            valid_d      = valid_in;
            reg_write_d  = valid_in & bus.i_MEM_reg_write &
                           (|bus.i_MEM_selected_reg) & ~misaligned;
            sel_reg_d    = bus.i_MEM_selected_reg;
            write_data_d = bus.i_MEM_mem_to_reg ? load_value : bus.i_MEM_alu_result;
            misaligned_d = misaligned;
            if (valid_in && bus.i_MEM_halt) begin
                halt_d = 1'b1;
            end
            if (valid_in && (retired_q != CNT_MAX)) begin
                retired_d = retired_q + NB_CNT'(1);
            end
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            valid_q      <= 1'b0;
            reg_write_q  <= 1'b0;
            sel_reg_q    <= '0;
            write_data_q <= '0;
            misaligned_q <= 1'b0;
            halt_q       <= 1'b0;
            retired_q    <= '0;
        end else begin
            valid_q      <= valid_d;
            reg_write_q  <= reg_write_d;
            sel_reg_q    <= sel_reg_d;
            write_data_q <= write_data_d;
            misaligned_q <= misaligned_d;
            halt_q       <= halt_d;
            retired_q    <= retired_d;
        end
    end

    assign bus.o_WB_valid        = valid_q;
    assign bus.o_WB_reg_write    = reg_write_q;
    assign bus.o_WB_selected_reg = sel_reg_q;
    assign bus.o_WB_write_data   = write_data_q;
    assign bus.o_WB_misaligned   = misaligned_q;
    assign bus.o_WB_halt         = halt_q;
    assign bus.o_WB_retired      = retired_q;

endmodule

`default_nettype wire

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- MEM/WB pipeline register plus write-back unit of the 5-stage MIPS pipeline; directly downstream of the MEM stage.
- Captures the MEM-stage outputs once per advancing cycle and extracts the load value from the raw memory word (byte/halfword lane select, sign/zero extension).
- Selects the register-file write data, tracks the pipeline halt and counts retired instructions for the debug unit.

Parameters:
- NB_DATA, 32, data/ALU width
- NB_REG, 5, register index width
- NB_CNT, 16, retired-instruction counter width

Ports:
- i_clock  in  1  system clock, rising edge
- i_reset  in  1  asynchronous, active-low reset
- i_enable  in  1  pipeline advance (debug step/run); 0 = hold
- i_flush  in  1  insert bubble
- i_MEM_valid  in  1  MEM holds a real instruction
- i_MEM_reg_write  in  1  instruction writes a register
- i_MEM_mem_to_reg  in  1  1 = write load data, 0 = ALU result
- i_MEM_byte_en  in  1  byte access
- i_MEM_halfword_en  in  1  halfword access
- i_MEM_word_en  in  1  word access
- i_MEM_unsigned  in  1  zero-extend load (LBU/LHU)
- i_MEM_halt  in  1  HALT instruction
- i_MEM_mem_data  in  NB_DATA  raw memory word at address alu_result[31:2]
- i_MEM_alu_result  in  NB_DATA  ALU result / byte address
- i_MEM_selected_reg  in  NB_REG  destination register
- o_WB_valid  out  1  WB holds a real instruction
- o_WB_reg_write  out  1  register-file write enable
- o_WB_selected_reg  out  NB_REG  write address
- o_WB_write_data  out  NB_DATA  write data
- o_WB_misaligned  out  1  misaligned-load flag (optional feature)
- o_WB_halt  out  1  sticky halt reached
- o_WB_retired  out  NB_CNT  retired-instruction count

Behaviour:
- Reset (i_reset=0, asynchronous): all outputs 0. Counter 0, halt flag clear.
- Latency: 1 cycle from MEM inputs to WB outputs. All outputs are registered; no combinational path from input to output.
- Capture: on a rising edge with i_enable=1 and i_flush=0, latch every MEM input.
  - o_WB_valid <= i_MEM_valid.
- Hold: i_enable=0 and i_flush=0 leaves all outputs unchanged.
- Flush: i_flush=1 has priority over i_enable. On the edge, valid, reg_write and misaligned go to 0; data and register outputs go to 0.
- Load extraction, offset = alu_result[1:0]; lane 0 = bits [7:0]:
  - byte: lane = offset.
  - halfword: lower half if offset[1]=0, else upper half.
  - word: the whole word.
  - Extension: sign-extend unless i_MEM_unsigned=1, then zero-extend.
  - Several size enables asserted together: priority word > halfword > byte. None asserted: the whole word.
- Write data: extracted load value when mem_to_reg=1, else alu_result.
- o_WB_reg_write = valid & reg_write & (selected_reg != 0) & ~halted & ~misaligned. Writes to r0 are always suppressed.
- Halt:
  - When a valid HALT is captured, o_WB_halt is set on the same edge and stays set until reset.
  - While set: later captures produce valid=0 and reg_write=0, and the counter freezes.
- Retired counter:
  - +1 on each capture edge with i_MEM_valid=1, not halted, no flush. The HALT instruction itself counts.
  - Saturates at 2^NB_CNT-1, no wrap.
- Reset mid-operation clears the halt flag and the counter immediately.

Optional Feature:
- Macro: MEM_WB_MISALIGN_TRAP_EN.
- Defined:
  - Halfword load with offset[0]=1, or word load with offset!=0, sets o_WB_misaligned=1 for that WB instruction.
  - Its register write is suppressed; it still counts as retired.
- Undefined:
  - o_WB_misaligned is tied 0.
  - The low address bits a size ignores are ignored: offset[0] for halfword loads, offset[1:0] for word loads.

Test Plan:
- Reset: i_reset=0 mid-run with counter=5 and halt set -> all outputs 0 immediately; counter 0, halt clear after release.
- Byte loads, mem_data=32'h80FF_7F01, alu_result=3:
  - signed -> write_data=32'hFFFF_FF80.
  - unsigned -> 32'h0000_0080.
  - Both with reg_write asserted for selected_reg=4.
- Halfword loads, mem_data=32'h8001_1234:
  - alu_result=2, signed -> 32'hFFFF_8001.
  - alu_result=0 -> 32'h0000_1234.
  - Feature on, alu_result=1 -> misaligned=1, reg_write=0.
- Pipeline control:
  - i_enable=0 for 3 cycles with changing inputs -> outputs frozen.
  - i_flush=1 with i_enable=0 -> bubble: valid=0, reg_write=0.
  - ALU path, mem_to_reg=0, alu_result=257 -> write_data=257.
  - selected_reg=0 -> reg_write=0.
- Halt: 3 valid instructions then HALT then 2 more valid -> o_WB_halt=1 from the HALT edge; retired=4 stays 4; later reg_write=0.
- Saturation: NB_CNT=4, 20 valid captures -> retired stops at 15.
